// File: rtl/game_session_if.sv
// Session-control bus between the game FSM / score block (master side) and
// game_session_ctrl (slave side). Carries the game events, the registered
// score read back from the score block, and every controller output.
interface game_session_if;
  logic        start;
  logic        solved;
  logic        give_up;
  logic        pause;
  logic [6:0]  score_in;
  logic [10:0] timer;
  logic        playing_condition;
  logic [2:0]  state;
  logic [6:0]  final_score;
  logic [6:0]  best_score;
  logic        won;
  logic        done_pulse;

  modport master (
    output start, solved, give_up, pause, score_in,
    input  timer, playing_condition, state, final_score, best_score, won, done_pulse
  );

  modport slave (
    input  start, solved, give_up, pause, score_in,
    output timer, playing_condition, state, final_score, best_score, won, done_pulse
  );
endinterface

// File: rtl/game_session_ctrl.sv
// Sudoku game-session sequencer: owns the elapsed-seconds timer and the
// playing_condition flag for the score datapath, captures the score when a
// game ends and keeps the best winning score since reset.
// Optional feature: define GAME_PAUSE_EN to enable the PAUSED state and the
// pause input; without it pause is ignored and PAUSED is never entered.
module game_session_ctrl #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int TIME_LIMIT    = 1800
) (
  input logic           clk,
  input logic           rst_n,
  game_session_if.slave bus
);

  localparam int              PW         = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [10:0]     LIMIT      = 11'(TIME_LIMIT);
  localparam logic [10:0]     TIMER_MAX  = 11'h7FF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAYING = 3'd1,
    ST_PAUSED  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [10:0]   timer_q, timer_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cap_won_q, cap_won_d;  // result decided on entry to CAPTURE
  logic [6:0]    final_q, final_d;
  logic [6:0]    best_q, best_d;
  logic          won_q, won_d;
  logic          done_q, done_d;
  logic          pc_q, pc_d;

`ifndef GAME_PAUSE_EN
  // pause is part of the bus but has no effect in this build.
  logic unused_pause;
  assign unused_pause = bus.pause;
`endif

  // Next-state, timer/prescaler and result-capture logic.
  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    presc_d   = presc_q;
    cap_won_d = cap_won_q;
    final_d   = final_q;
    best_d    = best_q;
    won_d     = won_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_PLAYING;
          timer_d = '0;
          presc_d = '0;
          won_d   = 1'b0;
        end
      end

      ST_PLAYING: begin
        // Any exit from PLAYING suppresses that edge's tick.
        if (bus.give_up) begin
          state_d   = ST_CAPTURE;
          cap_won_d = 1'b0;
        end else if (bus.solved) begin
          state_d   = ST_CAPTURE;
          cap_won_d = 1'b1;
        end else if (timer_q >= LIMIT) begin
          state_d   = ST_CAPTURE;
          cap_won_d = 1'b0;
`ifdef GAME_PAUSE_EN
        end else if (bus.pause) begin
          state_d = ST_PAUSED;
`endif
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (timer_q != TIMER_MAX) timer_d = timer_q + 11'd1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

`ifdef GAME_PAUSE_EN
      ST_PAUSED: begin
        // Timer and prescaler hold; give_up beats a simultaneous pause.
        if (bus.give_up) begin
          state_d   = ST_CAPTURE;
          cap_won_d = 1'b0;
        end else if (bus.pause) begin
          state_d = ST_PLAYING;
        end
      end
`endif

      ST_CAPTURE: begin
        // The score block sampled the frozen timer on the previous edge,
        // so score_in is settled here.
        state_d = ST_DONE;
        done_d  = 1'b1;
        won_d   = cap_won_q;
        final_d = cap_won_q ? bus.score_in : 7'd0;
        if (cap_won_q && (bus.score_in > best_q)) best_d = bus.score_in;
      end

      default: state_d = ST_IDLE;
    endcase

    pc_d = (state_d == ST_PLAYING) || (state_d == ST_PAUSED) ||
           (state_d == ST_CAPTURE);
  end

  // State and output registers; reset discards any game in progress.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      presc_q   <= '0;
      cap_won_q <= 1'b0;
      final_q   <= '0;
      best_q    <= '0;
      won_q     <= 1'b0;
      done_q    <= 1'b0;
      pc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      presc_q   <= presc_d;
      cap_won_q <= cap_won_d;
      final_q   <= final_d;
      best_q    <= best_d;
      won_q     <= won_d;
      done_q    <= done_d;
      pc_q      <= pc_d;
    end
  end

  assign bus.state             = state_q;
  assign bus.timer             = timer_q;
  assign bus.playing_condition = pc_q;
  assign bus.final_score       = final_q;
  assign bus.best_score        = best_q;
  assign bus.won               = won_q;
  assign bus.done_pulse        = done_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Self-checking bench for game_session_ctrl (TICKS_PER_SEC=4, TIME_LIMIT=20).
// A behavioural model counts active playing cycles and derives the timer as
// active/TICKS; a compare process checks every output on each falling edge.
// Directed scenarios add literal expectations, followed by random events.
module tb_game_session_ctrl;

  localparam int TICKS = 4;
  localparam int LIMIT = 20;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  game_session_if bus ();

  game_session_ctrl #(.TICKS_PER_SEC(TICKS), .TIME_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Score block stand-in: registered score driven by timer and playing_condition.
  function automatic logic [6:0] score_of(input logic [10:0] t);
    if (t < 11'd10)  return 7'd100;
    if (t < 11'd100) return 7'(110 - int'(t));
    return 7'd10;
  endfunction

  logic [6:0] score_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     score_q <= 7'd0;
    else if (bus.playing_condition) score_q <= score_of(bus.timer);
  end
  assign bus.score_in = score_q;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: timer = active playing cycles / TICKS.
  int m_state, m_active, m_final, m_best;
  bit m_cap, m_won, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_active <= 0; m_final <= 0; m_best <= 0;
      m_cap <= 0; m_won <= 0; m_done <= 0;
    end else begin
      m_done <= (m_state == 3);
      case (m_state)
        0, 4: if (bus.start) begin m_state <= 1; m_active <= 0; m_won <= 0; end
        1: begin
          if (bus.give_up)                  begin m_state <= 3; m_cap <= 0; end
          else if (bus.solved)              begin m_state <= 3; m_cap <= 1; end
          else if (m_active / TICKS >= LIMIT) begin m_state <= 3; m_cap <= 0; end
          else if (PAUSE_ON && bus.pause)   m_state <= 2;
          else                              m_active <= m_active + 1;
        end
        2: begin
          if (bus.give_up)    begin m_state <= 3; m_cap <= 0; end
          else if (bus.pause) m_state <= 1;
        end
        3: begin
          m_state <= 4;
          m_won   <= m_cap;
          m_final <= m_cap ? int'(bus.score_in) : 0;
          if (m_cap && int'(bus.score_in) > m_best) m_best <= int'(bus.score_in);
        end
        default: m_state <= 0;
      endcase
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    int exp_timer;
    exp_timer = m_active / TICKS;
    if (exp_timer > 2047) exp_timer = 2047;
    check("m_state",   int'(bus.state),             m_state);
    check("m_timer",   int'(bus.timer),             exp_timer);
    check("m_pc",      int'(bus.playing_condition), int'(m_state inside {1, 2, 3}));
    check("m_final",   int'(bus.final_score),       m_final);
    check("m_best",    int'(bus.best_score),        m_best);
    check("m_won",     int'(bus.won),               int'(m_won));
    check("m_done",    int'(bus.done_pulse),        int'(m_done));
  end

  // Present one set of event inputs for exactly one rising edge.
  task automatic cyc(input logic s, input logic so, input logic g, input logic p);
    bus.start = s; bus.solved = so; bus.give_up = g; bus.pause = p;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.solved = 1'b0; bus.give_up = 1'b0; bus.pause = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, int'(bus.state), 0);
    check({tag, "_timer"}, int'(bus.timer), 0);
    check({tag, "_pc"},    int'(bus.playing_condition), 0);
    check({tag, "_final"}, int'(bus.final_score), 0);
    check({tag, "_best"},  int'(bus.best_score), 0);
    check({tag, "_won"},   int'(bus.won), 0);
    check({tag, "_done"},  int'(bus.done_pulse), 0);
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.solved = 1'b0; bus.give_up = 1'b0; bus.pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    check_all_zero("idle");

    // Win after 12 cycles of play: timer 3, score 100.
    cyc(1, 0, 0, 0);
    check("start_state", int'(bus.state), 1);
    check("start_timer", int'(bus.timer), 0);
    repeat (12) cyc(0, 0, 0, 0);
    check("win_timer_before", int'(bus.timer), 3);
    cyc(0, 1, 0, 0);
    check("win_capture_state", int'(bus.state), 3);
    check("win_capture_timer", int'(bus.timer), 3);
    check("win_capture_done",  int'(bus.done_pulse), 0);
    cyc(0, 0, 0, 0);
    check("win_done_state", int'(bus.state), 4);
    check("win_final",      int'(bus.final_score), 100);
    check("win_won",        int'(bus.won), 1);
    check("win_best",       int'(bus.best_score), 100);
    check("win_pulse",      int'(bus.done_pulse), 1);
    check("win_pc",         int'(bus.playing_condition), 0);
    cyc(0, 0, 0, 0);
    check("win_pulse_end",  int'(bus.done_pulse), 0);
    check("win_timer_hold", int'(bus.timer), 3);

    // Timeout: timer reaches LIMIT, then CAPTURE, then DONE as lost.
    cyc(1, 0, 0, 0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cyc(0, 0, 0, 0);
      if (bus.state == 3'd4) hit = 1'b1;
    end
    check("timeout_reached", int'(hit), 1);
    check("timeout_timer", int'(bus.timer), LIMIT);
    check("timeout_won",   int'(bus.won), 0);
    check("timeout_final", int'(bus.final_score), 0);
    check("timeout_best",  int'(bus.best_score), 100);

    // solved and give_up together: give_up wins.
    cyc(1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    check("both_state", int'(bus.state), 4);
    check("both_won",   int'(bus.won), 0);
    check("both_final", int'(bus.final_score), 0);

    // Pause mid-second at timer 2, hold 40 cycles, resume.
    cyc(1, 0, 0, 0);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      cyc(0, 0, 0, 0);
      if (bus.timer == 11'd2) hit = 1'b1;
    end
    check("pause_timer2_reached", int'(hit), 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (40) cyc(0, 0, 0, 0);
    if (PAUSE_ON) begin
      check("paused_state", int'(bus.state), 2);
      check("paused_timer", int'(bus.timer), 2);
      check("paused_pc",    int'(bus.playing_condition), 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      check("resume_timer_hold", int'(bus.timer), 2);
      cyc(0, 0, 0, 0);
      check("resume_timer_inc",  int'(bus.timer), 3);
    end else begin
      check("nopause_state",  int'(bus.state), 1);
      check("nopause_timer",  int'(bus.timer), 12);
      cyc(0, 0, 0, 1);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    check("pause_end_state", int'(bus.state), 4);

    // Random event stream, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 79) == 0, $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset while in CAPTURE.
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    check("arst_pre_playing", int'(bus.state), 1);
    repeat (6) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check("arst_pre_capture", int'(bus.state), 3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("arst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cyc(0, 0, 0, 0);
    check_all_zero("arst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_session_ctrl.md
# game_session_ctrl

Sequencer for one Sudoku game session. It owns the elapsed-seconds counter and the `playing_condition` flag that feed the score datapath. It captures the registered score when the board is solved and keeps a best-score record. It sits between the game FSM (start/solved/give-up events) and the score block, whose registered output it reads back.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 50000000: clock cycles per timer second; minimum 2.
- `TIME_LIMIT`, default 1800: timer value (seconds) at which the game ends as lost; range 1..2047.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; starts a new game.
- `solved`  in  1  single-cycle pulse; the board is completely and correctly filled.
- `give_up`  in  1  single-cycle pulse; the player abandons the game.
- `pause`  in  1  single-cycle pulse; toggles pause. Active only with `GAME_PAUSE_EN`.
- `score_in`  in  7  registered score from the score block; it must be driven by `timer` and `playing_condition` from this block.
- `timer`  out  11  elapsed seconds.
- `playing_condition`  out  1  high while the score datapath must track the timer.
- `state`  out  3  FSM state: IDLE=0, PLAYING=1, PAUSED=2, CAPTURE=3, DONE=4.
- `final_score`  out  7  score of the last finished game.
- `best_score`  out  7  highest `final_score` of any won game since reset.
- `won`  out  1  the last finished game was won.
- `done_pulse`  out  1  one-cycle strobe on entry to DONE.

## Operation
Reset values:
- state = IDLE
- timer = 0, prescaler = 0
- final_score = 0, best_score = 0
- won = 0, done_pulse = 0, playing_condition = 0

Transitions:
- **IDLE**: on `start`, go to PLAYING. Clear the timer and prescaler, and clear `won`.
- **PLAYING**: the prescaler counts 0..TICKS_PER_SEC-1. On wrap, the timer increments, saturating at 2047. Events are handled in this priority order:
  1. `give_up` → CAPTURE(lost).
  2. `solved` → CAPTURE(won).
  3. Timer equal to TIME_LIMIT → CAPTURE(lost).
  4. `pause` → PAUSED.
  5. Tick.
  
  Any transition out of PLAYING suppresses the tick on that same edge. `start` is ignored.
- **PAUSED**: the prescaler and timer hold.
  - `pause` → PLAYING, with the prescaler resuming from its held value.
  - `give_up` → CAPTURE(lost); `give_up` wins over a simultaneous `pause`.
  - `solved` and `start` are ignored.
- **CAPTURE**: lasts exactly one cycle, with the timer frozen. On exit to DONE:
  - `final_score` takes `score_in` if won, otherwise 0.
  - `won` takes the capture result.
  - If won and `score_in` > `best_score`, `best_score` takes `score_in`.
  - All inputs are ignored during CAPTURE.
- **DONE**: `timer` holds its final value.
  - `start` → PLAYING, clearing the timer and prescaler and clearing `won`.
  - `final_score` and `best_score` hold until the next capture.

Output rules:
- `playing_condition` = 1 in PLAYING, PAUSED and CAPTURE; 0 in IDLE and DONE.
- The timer is an unsigned 11-bit saturating counter. Comparison against TIME_LIMIT uses `>=`.
- `rst_n` asserted in any state immediately forces all reset values; an in-progress game is discarded.

## Timing
- `start` sampled at edge N: `state`=PLAYING and `timer`=0 after edge N. The first increment lands at edge N+TICKS_PER_SEC.
- `solved` sampled at edge N: CAPTURE after edge N. The score block samples the frozen `timer` at edge N. `score_in` is captured at edge N+1; `final_score`, `won`, `best_score`, `state`=DONE and `done_pulse`=1 are all visible after edge N+1.
- `done_pulse` is high for exactly one cycle.
- Timeout: the timer reaches TIME_LIMIT at edge N; CAPTURE after edge N+1; DONE after edge N+2.
- No output is combinational from inputs; all are registered.

## Configuration
- `GAME_PAUSE_EN` defined: the PAUSED state and the `pause` input are functional.
- `GAME_PAUSE_EN` undefined: the `pause` port exists but is ignored. PAUSED is unreachable and is not synthesized; `state` never reads 2.

## Test plan
- Reset with no stimulus, `TICKS_PER_SEC`=4, `TIME_LIMIT`=20 → all outputs 0, `state`=0.
- `start`, wait 12 cycles, then `solved`, with `score_in` modelled as the score block → `timer`=3 and stays frozen; DONE 2 edges after `solved` (one in CAPTURE, one to DONE); `final_score`=100, `won`=1, `best_score`=100, one-cycle `done_pulse`.
- `start`, then run with no events → `timer` counts to 20, then `state` goes 3→4 with `won`=0, `final_score`=0, and `best_score` unchanged.
- `solved` and `give_up` in the same cycle → lost: `won`=0, `final_score`=0.
- `GAME_PAUSE_EN`: `pause` at `timer`=2, hold 40 cycles, then `pause` → `timer` stays 2 while paused and the prescaler resumes without restarting. Without the macro, the same stimulus leaves `timer` counting.
- Assert `rst_n` low while `state`=CAPTURE → all outputs return to their reset values on the next evaluation, with no dependence on a clock edge.
